// File: rtl/mem_access_pkg.sv
// Shared types and default widths for the memory-access pipeline stage.
package mem_access_pkg;

    localparam int unsigned DefDw      = 16;
    localparam int unsigned DefAw      = 16;
    localparam int unsigned DefCw      = 6;
    localparam int unsigned DefTimeout = 15;

    typedef enum logic {
        StIdle,
        StWait
    } state_e;

    typedef enum logic [1:0] {
        OpNone  = 2'b00,
        OpLoad  = 2'b01,
        OpStore = 2'b10
    } op_e;

    // A store takes priority when both op flags are raised.
    function automatic op_e decode_op(input logic load, input logic store);
        if (store) begin
            return OpStore;
        end
        if (load) begin
            return OpLoad;
        end
        return OpNone;
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Execute-side handshake, data-memory port and writeback bundle of the memory-access stage.
interface mem_access_if
    import mem_access_pkg::*;
#(
    parameter int unsigned DW = DefDw,
    parameter int unsigned AW = DefAw,
    parameter int unsigned CW = DefCw
);
    logic          in_valid;
    logic          in_ready;
    logic          in_load;
    logic          in_store;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_wdata;
    logic [DW-1:0] in_result;
    logic [CW-1:0] in_ctrl;

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;

    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic          out_err;

    // The stage itself.
    modport slave (
        input  in_valid, in_load, in_store, in_addr, in_wdata, in_result, in_ctrl,
        input  mem_ack, mem_rdata,
        output in_ready, mem_req, mem_we, mem_addr, mem_wdata,
        output out_valid, out_data, out_ctrl, out_err
    );

    // Surrounding pipeline and memory.
    modport master (
        output in_valid, in_load, in_store, in_addr, in_wdata, in_result, in_ctrl,
        output mem_ack, mem_rdata,
        input  in_ready, mem_req, mem_we, mem_addr, mem_wdata,
        input  out_valid, out_data, out_ctrl, out_err
    );

endinterface

// File: rtl/mem_timeout_ctr.sv
// Counts cycles spent waiting for mem_ack; expired is high during the TIMEOUT-th wait cycle.
module mem_timeout_ctr #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic en,
    output logic expired
);
    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            cnt_q <= '0;
        end else if (en && !expired) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired = (cnt_q == CntW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_stage.sv
// Registered memory-access stage between Execute and Writeback.
// Optional bus timeout compiled in with MEM_TIMEOUT_EN.
module mem_access_stage
    import mem_access_pkg::*;
#(
    parameter int unsigned DW      = DefDw,
    parameter int unsigned AW      = DefAw,
    parameter int unsigned CW      = DefCw,
    parameter int unsigned TIMEOUT = DefTimeout
) (
    input logic          clk,
    input logic          resetn,
    input logic          flush,
    mem_access_if.slave  bus
);
    state_e        state_q, state_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [CW-1:0] ctrl_q, ctrl_d;
    logic          killed_q, killed_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic [CW-1:0] out_ctrl_q, out_ctrl_d;
    logic          out_err_q, out_err_d;
    logic          timeout_expired;
    logic          kill;
    op_e           op;

`ifdef MEM_TIMEOUT_EN
    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (state_q == StIdle),
        .en      (state_q == StWait),
        .expired (timeout_expired)
    );
`else
    assign timeout_expired = 1'b0;
    // TIMEOUT only matters when the bus timeout is compiled in.
    if (TIMEOUT == 0) begin : g_timeout_unused
    end
`endif

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        ctrl_d      = ctrl_q;
        killed_d    = killed_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_ctrl_d  = out_ctrl_q;
        out_err_d   = out_err_q;
        kill        = 1'b0;
        op          = decode_op(bus.in_load, bus.in_store);

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid && !flush) begin
                    if (op == OpNone) begin
                        out_valid_d = 1'b1;
                        out_data_d  = bus.in_result;
                        out_ctrl_d  = bus.in_ctrl;
                        out_err_d   = 1'b0;
                    end else begin
                        state_d     = StWait;
                        mem_req_d   = 1'b1;
                        mem_we_d    = (op == OpStore);
                        mem_addr_d  = bus.in_addr;
                        mem_wdata_d = bus.in_wdata;
                        ctrl_d      = bus.in_ctrl;
                        killed_d    = 1'b0;
                    end
                end
            end
            StWait: begin
                // A flush never aborts the bus cycle; it only hides the writeback.
                kill     = killed_q | flush;
                killed_d = kill;
                if (bus.mem_ack || timeout_expired) begin
                    state_d     = StIdle;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    killed_d    = 1'b0;
                    if (!kill) begin
                        out_valid_d = 1'b1;
                        out_ctrl_d  = ctrl_q;
                        out_err_d   = !bus.mem_ack;
                        out_data_d  = (mem_we_q || !bus.mem_ack) ? '0 : bus.mem_rdata;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= StIdle;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ctrl_q      <= '0;
            killed_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ctrl_q  <= '0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            ctrl_q      <= ctrl_d;
            killed_q    <= killed_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ctrl_q  <= out_ctrl_d;
            out_err_q   <= out_err_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ctrl  = out_ctrl_q;
    assign bus.out_err   = out_err_q;

endmodule
